// File: rtl/rvv_alu_seq_if.sv
// Issue channel from the core into the vector ALU sequencer.
// One decoded arithmetic instruction per valid/ready transfer.
interface rvv_alu_seq_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_opcode;
  logic [2:0]  issue_op_type;
  logic        issue_mask;
  logic [2:0]  issue_vsew;
  logic [10:0] issue_vl;
  logic [4:0]  issue_vd;

  modport master (
    output issue_valid,
    output issue_opcode,
    output issue_op_type,
    output issue_mask,
    output issue_vsew,
    output issue_vl,
    output issue_vd,
    input  issue_ready
  );

  modport slave (
    input  issue_valid,
    input  issue_opcode,
    input  issue_op_type,
    input  issue_mask,
    input  issue_vsew,
    input  issue_vl,
    input  issue_vd,
    output issue_ready
  );
endinterface

// File: rtl/rvv_alu_seq.sv
// Vector ALU sequencer: drives the lane wrapper for one instruction
// and turns its lane results into registered write-back beats.
module rvv_alu_seq #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int NB_LANES   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  rvv_alu_seq_if.slave               iss,
  output logic                       alu_run,
  output logic [5:0]                 alu_opcode,
  output logic [2:0]                 alu_op_type,
  output logic                       alu_mask,
  output logic [2:0]                 alu_vsew,
  output logic [10:0]                alu_vl,
  output logic [10:0]                alu_arith_remaining,
  input  logic                       alu_done,
  input  logic                       alu_instr_valid,
  input  logic [(64<<NB_LANES)-1:0]  alu_vd,
  input  logic [(10<<NB_LANES)-1:0]  alu_regi,
  input  logic [(1<<NB_LANES)-1:0]   alu_res,
  output logic                       wb_valid,
  output logic [4:0]                 wb_addr,
  output logic [(64<<NB_LANES)-1:0]  wb_data,
  output logic [(10<<NB_LANES)-1:0]  wb_index,
  output logic [(1<<NB_LANES)-1:0]   wb_lmask,
  output logic [3:0]                 wb_part,
  output logic                       complete,
  output logic                       illegal
);

  localparam int NL = 1 << NB_LANES;
  localparam int DW = 64 << NB_LANES;
  localparam int IW = 10 << NB_LANES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  function automatic logic [10:0] calc_total(
    input logic        mask,
    input logic [2:0]  vsew,
    input logic [10:0] vl
  );
    int cap;
    cap = VLEN >> (int'(vsew) + 3);
    if (cap > 2047) cap = 2047;
    if (!mask && int'(vl) < cap) cap = int'(vl);
    return 11'(cap);
  endfunction

  function automatic logic [10:0] calc_step(
    input logic [10:0] vl
  );
    int m;
    int s;
    m = (int'(vl) < NL) ? int'(vl) : NL;
    s = 1;
    for (int i = 1; i <= NB_LANES; i++) begin
      if (m >= (1 << i)) s = 1 << i;
    end
    return 11'(s);
  endfunction

  // Elements wider than a lane take several sub-chunk cycles.
  function automatic logic [3:0] calc_subs_last(
    input logic [2:0] vsew
  );
    int sh;
    sh = int'(vsew) + 3 - LANE_WIDTH;
    if (sh < 0) sh = 0;
    if (sh > 4) sh = 4;
    return 4'((1 << sh) - 1);
  endfunction

  state_e        state_q, state_d;
  logic          ready_q, ready_d;
  logic          run_q, run_d;
  logic          first_q, first_d;
  logic [5:0]    opc_q, opc_d;
  logic [2:0]    opt_q, opt_d;
  logic          mask_q, mask_d;
  logic [2:0]    vsew_q, vsew_d;
  logic [10:0]   vl_q, vl_d;
  logic [4:0]    vd_q, vd_d;
  logic [10:0]   rem_q, rem_d;
  logic [10:0]   step_q, step_d;
  logic [3:0]    subl_q, subl_d;
  logic [3:0]    part_q, part_d;
  logic          wbv_q, wbv_d;
  logic [4:0]    wba_q, wba_d;
  logic [DW-1:0] wbd_q, wbd_d;
  logic [IW-1:0] wbi_q, wbi_d;
  logic [NL-1:0] wbm_q, wbm_d;
  logic [3:0]    wbp_q, wbp_d;
  logic          cpl_q, cpl_d;
  logic          ill_q, ill_d;

  logic [10:0]   total_w;
  logic [10:0]   step_w;
  logic [3:0]    subl_w;

  assign total_w = calc_total(iss.issue_mask,
                              iss.issue_vsew,
                              iss.issue_vl);
  assign step_w  = calc_step(iss.issue_vl);
  assign subl_w  = calc_subs_last(iss.issue_vsew);

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    run_d   = run_q;
    first_d = first_q;
    opc_d   = opc_q;
    opt_d   = opt_q;
    mask_d  = mask_q;
    vsew_d  = vsew_q;
    vl_d    = vl_q;
    vd_d    = vd_q;
    rem_d   = rem_q;
    step_d  = step_q;
    subl_d  = subl_q;
    part_d  = part_q;
    wbv_d   = 1'b0;
    wba_d   = wba_q;
    wbd_d   = wbd_q;
    wbi_d   = wbi_q;
    wbm_d   = wbm_q;
    wbp_d   = wbp_q;
    cpl_d   = 1'b0;
    ill_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (iss.issue_valid && ready_q) begin
          opc_d   = iss.issue_opcode;
          opt_d   = iss.issue_op_type;
          mask_d  = iss.issue_mask;
          vsew_d  = iss.issue_vsew;
          vl_d    = iss.issue_vl;
          vd_d    = iss.issue_vd;
          rem_d   = total_w;
          step_d  = step_w;
          subl_d  = subl_w;
          part_d  = 4'd0;
          first_d = 1'b1;
          ready_d = 1'b0;
          if (total_w == 11'd0) begin
            state_d = S_FIN;
            cpl_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            run_d   = 1'b1;
          end
        end
      end

      S_RUN: begin
        first_d = 1'b0;
        // Legality is only known once the wrapper has decoded.
        if (first_q && !alu_instr_valid) begin
          state_d = S_IDLE;
          run_d   = 1'b0;
          ready_d = 1'b1;
          ill_d   = 1'b1;
        end else begin
          if (alu_res != '0) begin
            wbv_d = 1'b1;
            wba_d = vd_q;
            wbd_d = alu_vd;
            wbi_d = alu_regi;
            wbm_d = alu_res;
            wbp_d = part_q;
          end
          if (part_q == subl_q) begin
            part_d = 4'd0;
            rem_d  = (rem_q > step_q) ?
                     rem_q - step_q : 11'd0;
          end else begin
            part_d = part_q + 4'd1;
          end
          if (alu_done) begin
            state_d = S_FIN;
            run_d   = 1'b0;
            cpl_d   = 1'b1;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        run_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      run_q   <= 1'b0;
      first_q <= 1'b0;
      opc_q   <= '0;
      opt_q   <= '0;
      mask_q  <= 1'b0;
      vsew_q  <= '0;
      vl_q    <= '0;
      vd_q    <= '0;
      rem_q   <= '0;
      step_q  <= '0;
      subl_q  <= '0;
      part_q  <= '0;
      wbv_q   <= 1'b0;
      wba_q   <= '0;
      wbd_q   <= '0;
      wbi_q   <= '0;
      wbm_q   <= '0;
      wbp_q   <= '0;
      cpl_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      run_q   <= run_d;
      first_q <= first_d;
      opc_q   <= opc_d;
      opt_q   <= opt_d;
      mask_q  <= mask_d;
      vsew_q  <= vsew_d;
      vl_q    <= vl_d;
      vd_q    <= vd_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
      subl_q  <= subl_d;
      part_q  <= part_d;
      wbv_q   <= wbv_d;
      wba_q   <= wba_d;
      wbd_q   <= wbd_d;
      wbi_q   <= wbi_d;
      wbm_q   <= wbm_d;
      wbp_q   <= wbp_d;
      cpl_q   <= cpl_d;
      ill_q   <= ill_d;
    end
  end

  assign iss.issue_ready     = ready_q;
  assign alu_run             = run_q;
  assign alu_opcode          = opc_q;
  assign alu_op_type         = opt_q;
  assign alu_mask            = mask_q;
  assign alu_vsew            = vsew_q;
  assign alu_vl              = vl_q;
  assign alu_arith_remaining = rem_q;
  assign wb_valid            = wbv_q;
  assign wb_addr             = wba_q;
  assign wb_data             = wbd_q;
  assign wb_index            = wbi_q;
  assign wb_lmask            = wbm_q;
  assign wb_part             = wbp_q;
  assign complete            = cpl_q;
  assign illegal             = ill_q;

endmodule

// File: doc/rvv_alu_seq.md
# rvv_alu_seq

Sequencer for the multi-lane vector ALU wrapper (`rvv_alu_wrapper`). It accepts one decoded vector arithmetic instruction at a time over a valid/ready handshake. It holds `run` and the instruction fields stable and maintains the per-step `arith_remaining` element count. It converts the wrapper's per-cycle lane results into registered register-file write beats, then reports completion or an illegal-instruction abort to the core.

## Interface
- `VLEN`, 128: vector register length in bits.
- `LANE_WIDTH`, 3: log2 of lane datapath width in bits.
- `NB_LANES`, 1: log2 of the lane count; the lane count is `1<<NB_LANES`.

Ports (name, direction, width, meaning):
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `issue_valid`, in, 1: instruction offered.
- `issue_ready`, out, 1: sequencer idle and able to accept.
- `issue_opcode`, in, 6: ALU opcode.
- `issue_op_type`, in, 3: operand type, one-hot (VV=001, VX=010, VI=100).
- `issue_mask`, in, 1: mask-producing instruction.
- `issue_vsew`, in, 3: element width code; element width is `8<<vsew`.
- `issue_vl`, in, 11: vector length.
- `issue_vd`, in, 5: destination register.
- `alu_run`, out, 1: run to the wrapper.
- `alu_opcode`, `alu_op_type`, `alu_mask`, `alu_vsew`, `alu_vl`, out: latched instruction fields.
- `alu_arith_remaining`, out, 11: elements not yet processed.
- `alu_done`, in, 1: wrapper done.
- `alu_instr_valid`, in, 1: wrapper decode-legal flag.
- `alu_vd`, in, `64<<NB_LANES`: lane results.
- `alu_regi`, in, `10<<NB_LANES`: lane element indices.
- `alu_res`, in, `1<<NB_LANES`: lane-active bits.
- `wb_valid`, out, 1: write beat.
- `wb_addr`, out, 5: destination register.
- `wb_data`, out, `64<<NB_LANES`: captured lane results.
- `wb_index`, out, `10<<NB_LANES`: captured lane element indices.
- `wb_lmask`, out, `1<<NB_LANES`: per-lane write enables.
- `wb_part`, out, 4: sub-chunk offset for elements wider than a lane.
- `complete`, out, 1: one-cycle completion pulse.
- `illegal`, out, 1: one-cycle abort pulse.

## Operation
States are IDLE, RUN and FINISH.

**IDLE**
- `issue_ready`=1.
- On `issue_valid&&issue_ready`:
  - Latch all fields.
  - Compute TOTAL:
    - If `issue_mask`=1, TOTAL = `VLEN>>(vsew+3)`.
    - Otherwise TOTAL = `min(vl, VLEN>>(vsew+3))`.
  - Compute STEP = largest power of two ≤ `min(vl, 1<<NB_LANES)`, with a minimum of 1.
  - Compute SUBS:
    - If `vsew+3 ≤ LANE_WIDTH`, SUBS = 1.
    - Otherwise SUBS = `1<<(vsew+3-LANE_WIDTH)`.
  - Set `arith_remaining` = TOTAL and `part`=0.
  - If TOTAL=0, go to FINISH. Otherwise go to RUN.

**RUN**
- `alu_run`=1.
- First RUN cycle: sample `alu_instr_valid`. If it is 0, go to IDLE, pulse `illegal` next cycle, and produce no `wb_valid` for this instruction.
- `part` counts 0..SUBS-1. On wrap, `arith_remaining` is decremented by STEP, saturating at 0. Otherwise it holds.
- Capture:
  - In every RUN cycle with `alu_res`≠0, register `alu_vd`, `alu_regi`, `alu_res`, `part` and the latched `vd` into the wb outputs.
  - `wb_valid` asserts the following cycle. The register file always accepts, so there is no backpressure.
- When `alu_done`=1, go to FINISH. The done cycle is still captured.

**FINISH**
- `alu_run`=0, `complete`=1 for one cycle, then go to IDLE.

**Boundaries**
- `issue_valid` while busy is ignored; `issue_ready`=0.
- Field outputs hold their latched values until the next accept.

## Timing
- Reset values: `issue_ready`=1 on the cycle after reset. All other outputs are 0, including `alu_run`, `wb_valid`, `complete`, `illegal` and `arith_remaining`. State is IDLE.
- Reset mid-RUN drops `alu_run` in the next cycle and discards pending wb beats.
- Accept at cycle T: `alu_run`=1 from T+1.
- Illegal: `alu_run`=0 at T+2 and `illegal`=1 at T+2.
- `alu_done` at cycle D: `alu_run`=0 and `complete`=1 at D+1. The last `wb_valid` is at D+1. `issue_ready`=1 at D+2.
- Back-to-back: a new accept is possible at D+2.
- TOTAL=0: `complete` at T+1. `alu_run` never rises.
- `arith_remaining` changes only at the clock edge ending a step (the `part` wrap).

## Test plan
All scenarios use VLEN=128, NB_LANES=1, LANE_WIDTH=3.

1. vsew=0, vl=16, mask=0 → 8 RUN steps; `arith_remaining` runs 16,14,…,2; 8 wb beats with `wb_lmask`=11; a single `complete`.
2. vsew=0, vl=3 → STEP=2; `arith_remaining` is 3 then 1; the final beat has `wb_lmask`=01; `complete` follows.
3. vsew=2, vl=4 → SUBS=4; `arith_remaining` holds 4 for 4 cycles, then 2 for 4 cycles; `wb_part` cycles 0..3 per step.
4. mask=1, vsew=0, vl=3 → TOTAL=16; `arith_remaining` starts at 16.
5. `alu_instr_valid`=0 → `illegal` at T+2; no `wb_valid` and no `complete`; `issue_ready`=1 at T+2; `issue_valid` held high during RUN is not accepted.
6. `reset` asserted during RUN of scenario 1 → next cycle `alu_run`=0, `wb_valid`=0, `arith_remaining`=0; a fresh issue then completes normally.
